// File: rtl/ddr_ctrl_pkg.sv
// Shared types and encodings for the HDR-DDR controller engine.
package ddr_ctrl_pkg;

   // Engine sequencing states
   typedef enum logic [2:0] {
      ST_IDLE_SDR    = 3'd0,
      ST_ENTHDR      = 3'd1,
      ST_DISPATCH    = 3'd2,
      ST_DDR_NT      = 3'd3,
      ST_CCC_HANDLER = 3'd4,
      ST_RESTART     = 3'd5,
      ST_EXIT        = 3'd6
   } ddr_state_t;

   // SDA/SCL driver select encodings
   localparam logic [1:0] MUX_ENGINE  = 2'b00;
   localparam logic [1:0] MUX_DDR_NT  = 2'b01;
   localparam logic [1:0] MUX_CCC     = 2'b10;
   localparam logic [1:0] MUX_PATTERN = 2'b11;

   // Head-of-queue command type encodings
   localparam logic [1:0] CMD_REG = 2'b01;
   localparam logic [1:0] CMD_CCC = 2'b10;

   // Pattern generator selection
   localparam logic PAT_RESTART = 1'b0;
   localparam logic PAT_EXIT    = 1'b1;

   // Per-state output bundle (abort and command count are handled separately)
   typedef struct packed {
      logic [1:0] muxes;
      logic       enthdr_en;
      logic       nt_en;
      logic       ccc_en;
      logic       pattern_en;
      logic       pattern_sel;
      logic       busy;
   } ddr_out_t;

   // Decode the driver mux and enables for a given state
   function automatic ddr_out_t decode_outputs(input ddr_state_t st);
      ddr_out_t o;
      o.muxes       = MUX_ENGINE;
      o.enthdr_en   = 1'b0;
      o.nt_en       = 1'b0;
      o.ccc_en      = 1'b0;
      o.pattern_en  = 1'b0;
      o.pattern_sel = PAT_RESTART;
      o.busy        = 1'b1;
      case (st)
         ST_IDLE_SDR: begin
            o.busy = 1'b0;
         end
         ST_ENTHDR: begin
            o.enthdr_en = 1'b1;
         end
         ST_DISPATCH: begin
            o.muxes = MUX_ENGINE;
         end
         ST_DDR_NT: begin
            o.muxes = MUX_DDR_NT;
            o.nt_en = 1'b1;
         end
         ST_CCC_HANDLER: begin
            o.muxes  = MUX_CCC;
            o.ccc_en = 1'b1;
         end
         ST_RESTART: begin
            o.muxes      = MUX_PATTERN;
            o.pattern_en = 1'b1;
         end
         ST_EXIT: begin
            o.muxes       = MUX_PATTERN;
            o.pattern_en  = 1'b1;
            o.pattern_sel = PAT_EXIT;
         end
         default: begin
            o.busy = 1'b0;
         end
      endcase
      return o;
   endfunction

endpackage

// File: rtl/ddr_controller_engine_watchdog.sv
// Per-command watchdog: counts occupancy cycles of a sub-engine state and
// flags expiry in the TIMEOUT-th cycle so the engine leaves on that edge.
module ddr_watchdog #(
   parameter int TIMEOUT = 1024
) (
   input  logic i_sys_clk,
   input  logic i_sys_rst,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LIMIT     = CW'(TIMEOUT);
   localparam logic [CW-1:0] EXPIRE_AT = CW'(TIMEOUT - 1);

   logic [CW-1:0] count_r;

   // Occupancy counter: cleared on entry, counts while enabled, saturates
   always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
      if (!i_sys_rst) begin
         count_r <= {CW{1'b0}};
      end else if (i_clear) begin
         count_r <= {CW{1'b0}};
      end else if (i_enable && (count_r != LIMIT)) begin
         count_r <= count_r + CW'(1);
      end else begin
         count_r <= count_r;
      end
   end

   // Count holds (occupancy - 1), so expiry shows in the TIMEOUT-th cycle
   assign o_expired = i_enable && (count_r >= EXPIRE_AT);

endmodule

// File: rtl/ddr_controller_engine.sv
// HDR-DDR initiator sequencing engine: ENTHDR, command dispatch to the NT or
// CCC sub-engine, restart patterns between commands and a closing exit pattern.
module ddr_controller_engine
   import ddr_ctrl_pkg::*;
#(
   parameter int TIMEOUT = 1024,
   parameter int CNT_W   = 8
) (
   input  logic             i_sys_clk,
   input  logic             i_sys_rst,
   input  logic             i_hdr_req,
   input  logic [1:0]       i_cmd_type,
   input  logic             i_more_cmds,
   input  logic             i_ENTHDR_done,
   input  logic             i_NT_done,
   input  logic             i_CCC_done,
   input  logic             i_sub_error,
   input  logic             i_pattern_done,
   output logic [1:0]       o_muxes,
   output logic             o_ENTHDR_en,
   output logic             o_NT_en,
   output logic             o_CCC_en,
   output logic             o_pattern_en,
   output logic             o_pattern_sel,
   output logic             o_abort,
   output logic             o_busy,
   output logic [CNT_W-1:0] o_cmd_cnt
);

   ddr_state_t       state_r;
   ddr_state_t       next_state_s;
   ddr_out_t         out_r;
   ddr_out_t         next_out_s;
   logic             abort_r;
   logic             abort_s;
   logic             cnt_inc_s;
   logic             cnt_clr_s;
   logic [CNT_W-1:0] cmd_cnt_r;
   logic             wd_clear_s;
   logic             wd_enable_s;
   logic             wd_expired_s;

   assign wd_clear_s  = (state_r == ST_DISPATCH);
   assign wd_enable_s = (state_r == ST_DDR_NT) || (state_r == ST_CCC_HANDLER);

   ddr_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .i_sys_clk (i_sys_clk),
      .i_sys_rst (i_sys_rst),
      .i_clear   (wd_clear_s),
      .i_enable  (wd_enable_s),
      .o_expired (wd_expired_s)
   );

   // Next-state, abort and counter-control decode; error beats done beats timeout
   always_comb begin
      next_state_s = state_r;
      abort_s      = 1'b0;
      cnt_inc_s    = 1'b0;
      cnt_clr_s    = 1'b0;
      case (state_r)
         ST_IDLE_SDR: begin
            if (i_hdr_req) begin
               next_state_s = ST_ENTHDR;
               cnt_clr_s    = 1'b1;
            end else begin
               next_state_s = ST_IDLE_SDR;
            end
         end
         ST_ENTHDR: begin
            if (i_ENTHDR_done) begin
               next_state_s = ST_DISPATCH;
            end else begin
               next_state_s = ST_ENTHDR;
            end
         end
         ST_DISPATCH: begin
            case (i_cmd_type)
               CMD_REG: next_state_s = ST_DDR_NT;
               CMD_CCC: next_state_s = ST_CCC_HANDLER;
               default: begin
                  next_state_s = ST_EXIT;
                  abort_s      = 1'b1;
               end
            endcase
         end
         ST_DDR_NT: begin
            if (i_sub_error) begin
               next_state_s = ST_EXIT;
               abort_s      = 1'b1;
            end else if (i_NT_done) begin
               cnt_inc_s    = 1'b1;
               next_state_s = i_more_cmds ? ST_RESTART : ST_EXIT;
            end else if (wd_expired_s) begin
               next_state_s = ST_EXIT;
               abort_s      = 1'b1;
            end else begin
               next_state_s = ST_DDR_NT;
            end
         end
         ST_CCC_HANDLER: begin
            if (i_sub_error) begin
               next_state_s = ST_EXIT;
               abort_s      = 1'b1;
            end else if (i_CCC_done) begin
               cnt_inc_s    = 1'b1;
               next_state_s = i_more_cmds ? ST_RESTART : ST_EXIT;
            end else if (wd_expired_s) begin
               next_state_s = ST_EXIT;
               abort_s      = 1'b1;
            end else begin
               next_state_s = ST_CCC_HANDLER;
            end
         end
         ST_RESTART: begin
            if (i_pattern_done) begin
               next_state_s = ST_DISPATCH;
            end else begin
               next_state_s = ST_RESTART;
            end
         end
         ST_EXIT: begin
            if (i_pattern_done) begin
               next_state_s = ST_IDLE_SDR;
            end else begin
               next_state_s = ST_EXIT;
            end
         end
         default: begin
            next_state_s = ST_IDLE_SDR;
         end
      endcase
   end

   assign next_out_s = decode_outputs(next_state_s);

   // State register with outputs registered from the next-state decode
   always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
      if (!i_sys_rst) begin
         state_r   <= ST_IDLE_SDR;
         out_r     <= decode_outputs(ST_IDLE_SDR);
         abort_r   <= 1'b0;
         cmd_cnt_r <= {CNT_W{1'b0}};
      end else begin
         state_r <= next_state_s;
         out_r   <= next_out_s;
         abort_r <= abort_s;
         if (cnt_clr_s) begin
            cmd_cnt_r <= {CNT_W{1'b0}};
         end else if (cnt_inc_s) begin
            cmd_cnt_r <= cmd_cnt_r + CNT_W'(1);
         end else begin
            cmd_cnt_r <= cmd_cnt_r;
         end
      end
   end

   assign o_muxes       = out_r.muxes;
   assign o_ENTHDR_en   = out_r.enthdr_en;
   assign o_NT_en       = out_r.nt_en;
   assign o_CCC_en      = out_r.ccc_en;
   assign o_pattern_en  = out_r.pattern_en;
   assign o_pattern_sel = out_r.pattern_sel;
   assign o_abort       = abort_r;
   assign o_busy        = out_r.busy;
   assign o_cmd_cnt     = cmd_cnt_r;

endmodule

// File: tb/tb_ddr_controller_engine.sv
// Directed self-checking bench for ddr_controller_engine (TIMEOUT = 16).
module tb_ddr_controller_engine;

   localparam int TIMEOUT = 16;
   localparam int CNT_W   = 8;

   // Expected output vectors: {muxes[1:0], enthdr, nt, ccc, pat_en, pat_sel, abort, busy}
   localparam logic [8:0] E_IDLE    = 9'b00_0000_000;
   localparam logic [8:0] E_ENTHDR  = 9'b00_1000_001;
   localparam logic [8:0] E_DISP    = 9'b00_0000_001;
   localparam logic [8:0] E_NT      = 9'b01_0100_001;
   localparam logic [8:0] E_CCC     = 9'b10_0010_001;
   localparam logic [8:0] E_RESTART = 9'b11_0001_001;
   localparam logic [8:0] E_EXIT    = 9'b11_0001_101;
   localparam logic [8:0] E_EXIT_AB = 9'b11_0001_111;

   logic             clk;
   logic             rst_n;
   logic             hdr_req;
   logic [1:0]       cmd_type;
   logic             more_cmds;
   logic             enthdr_done;
   logic             nt_done;
   logic             ccc_done;
   logic             sub_error;
   logic             pattern_done;
   logic [1:0]       muxes;
   logic             enthdr_en;
   logic             nt_en;
   logic             ccc_en;
   logic             pattern_en;
   logic             pattern_sel;
   logic             abort;
   logic             busy;
   logic [CNT_W-1:0] cmd_cnt;
   logic [8:0]       obs;

   int n_checks;
   int n_fail;

   ddr_controller_engine #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) dut (
      .i_sys_clk      (clk),
      .i_sys_rst      (rst_n),
      .i_hdr_req      (hdr_req),
      .i_cmd_type     (cmd_type),
      .i_more_cmds    (more_cmds),
      .i_ENTHDR_done  (enthdr_done),
      .i_NT_done      (nt_done),
      .i_CCC_done     (ccc_done),
      .i_sub_error    (sub_error),
      .i_pattern_done (pattern_done),
      .o_muxes        (muxes),
      .o_ENTHDR_en    (enthdr_en),
      .o_NT_en        (nt_en),
      .o_CCC_en       (ccc_en),
      .o_pattern_en   (pattern_en),
      .o_pattern_sel  (pattern_sel),
      .o_abort        (abort),
      .o_busy         (busy),
      .o_cmd_cnt      (cmd_cnt)
   );

   assign obs = {muxes, enthdr_en, nt_en, ccc_en, pattern_en, pattern_sel, abort, busy};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_pulses();
      enthdr_done  = 1'b0;
      nt_done      = 1'b0;
      ccc_done     = 1'b0;
      sub_error    = 1'b0;
      pattern_done = 1'b0;
   endtask

   task automatic start_session();
      hdr_req = 1'b1;
      step();
      hdr_req = 1'b0;
      check_eq("enter_enthdr", 32'(obs), 32'(E_ENTHDR));
      check_eq("cnt_cleared", 32'(cmd_cnt), 32'd0);
   endtask

   task automatic dispatch(input logic [1:0] ct, input logic more);
      cmd_type    = ct;
      more_cmds   = more;
      enthdr_done = 1'b1;
      step();
      clear_pulses();
      check_eq("dispatch", 32'(obs), 32'(E_DISP));
   endtask

   task automatic finish_exit();
      pattern_done = 1'b1;
      step();
      clear_pulses();
      check_eq("back_idle", 32'(obs), 32'(E_IDLE));
   endtask

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      rst_n     = 1'b1;
      hdr_req   = 1'b0;
      cmd_type  = 2'b00;
      more_cmds = 1'b0;
      clear_pulses();
      #1 rst_n = 1'b0;
      #2;
      check_eq("reset_outputs", 32'(obs), 32'(E_IDLE));
      check_eq("reset_cnt", 32'(cmd_cnt), 32'd0);
      step();
      step();
      rst_n = 1'b1;
      step();
      check_eq("post_reset_idle", 32'(obs), 32'(E_IDLE));

      // Single regular command, no more queued
      start_session();
      dispatch(2'b01, 1'b0);
      step();
      check_eq("single_nt", 32'(obs), 32'(E_NT));
      nt_done = 1'b1;
      step();
      clear_pulses();
      check_eq("single_exit", 32'(obs), 32'(E_EXIT));
      check_eq("single_cnt", 32'(cmd_cnt), 32'd1);
      finish_exit();
      check_eq("single_cnt_hold", 32'(cmd_cnt), 32'd1);

      // Three commands: NT, CCC, NT separated by restarts
      start_session();
      dispatch(2'b01, 1'b1);
      step();
      check_eq("seq_nt1", 32'(obs), 32'(E_NT));
      nt_done = 1'b1;
      step();
      clear_pulses();
      check_eq("seq_restart1", 32'(obs), 32'(E_RESTART));
      check_eq("seq_cnt1", 32'(cmd_cnt), 32'd1);
      cmd_type     = 2'b10;
      pattern_done = 1'b1;
      step();
      clear_pulses();
      check_eq("seq_disp2", 32'(obs), 32'(E_DISP));
      step();
      check_eq("seq_ccc", 32'(obs), 32'(E_CCC));
      nt_done = 1'b1;
      step();
      clear_pulses();
      check_eq("seq_ccc_ignores_nt_done", 32'(obs), 32'(E_CCC));
      ccc_done = 1'b1;
      step();
      clear_pulses();
      check_eq("seq_restart2", 32'(obs), 32'(E_RESTART));
      check_eq("seq_cnt2", 32'(cmd_cnt), 32'd2);
      cmd_type     = 2'b01;
      more_cmds    = 1'b0;
      pattern_done = 1'b1;
      step();
      clear_pulses();
      check_eq("seq_disp3", 32'(obs), 32'(E_DISP));
      step();
      check_eq("seq_nt3", 32'(obs), 32'(E_NT));
      nt_done = 1'b1;
      step();
      clear_pulses();
      check_eq("seq_exit", 32'(obs), 32'(E_EXIT));
      check_eq("seq_cnt3", 32'(cmd_cnt), 32'd3);
      finish_exit();

      // Watchdog expiry after exactly TIMEOUT cycles in DDR_NT
      start_session();
      dispatch(2'b01, 1'b0);
      step();
      check_eq("wd_nt_cycle1", 32'(obs), 32'(E_NT));
      for (int i = 2; i <= TIMEOUT; i++) begin
         step();
         check_eq($sformatf("wd_nt_cycle%0d", i), 32'(obs), 32'(E_NT));
      end
      step();
      check_eq("wd_exit_abort", 32'(obs), 32'(E_EXIT_AB));
      check_eq("wd_cnt_unchanged", 32'(cmd_cnt), 32'd0);
      step();
      check_eq("wd_abort_one_cycle", 32'(obs), 32'(E_EXIT));
      finish_exit();

      // Done in the TIMEOUT-th cycle wins over expiry
      start_session();
      dispatch(2'b01, 1'b0);
      for (int i = 1; i <= TIMEOUT; i++) begin
         step();
      end
      check_eq("wd2_still_nt", 32'(obs), 32'(E_NT));
      nt_done = 1'b1;
      step();
      clear_pulses();
      check_eq("wd2_exit_no_abort", 32'(obs), 32'(E_EXIT));
      check_eq("wd2_cnt", 32'(cmd_cnt), 32'd1);
      // hdr_req held through EXIT restarts one cycle after IDLE
      hdr_req      = 1'b1;
      pattern_done = 1'b1;
      step();
      clear_pulses();
      check_eq("held_req_idle", 32'(obs), 32'(E_IDLE));
      check_eq("held_req_cnt_hold", 32'(cmd_cnt), 32'd1);
      step();
      hdr_req = 1'b0;
      check_eq("held_req_enthdr", 32'(obs), 32'(E_ENTHDR));
      check_eq("held_req_cnt_clr", 32'(cmd_cnt), 32'd0);

      // Error and done together in CCC_HANDLER: error wins
      dispatch(2'b10, 1'b0);
      step();
      check_eq("err_ccc", 32'(obs), 32'(E_CCC));
      sub_error = 1'b1;
      ccc_done  = 1'b1;
      step();
      clear_pulses();
      check_eq("err_exit_abort", 32'(obs), 32'(E_EXIT_AB));
      check_eq("err_no_inc", 32'(cmd_cnt), 32'd0);
      finish_exit();

      // Invalid command type in DISPATCH
      start_session();
      dispatch(2'b11, 1'b0);
      step();
      check_eq("bad_cmd_exit_abort", 32'(obs), 32'(E_EXIT_AB));
      finish_exit();

      // Asynchronous reset while in CCC_HANDLER with a non-zero count
      start_session();
      dispatch(2'b10, 1'b1);
      step();
      ccc_done = 1'b1;
      step();
      clear_pulses();
      check_eq("rst_pre_restart", 32'(obs), 32'(E_RESTART));
      pattern_done = 1'b1;
      step();
      clear_pulses();
      step();
      check_eq("rst_pre_ccc", 32'(obs), 32'(E_CCC));
      check_eq("rst_pre_cnt", 32'(cmd_cnt), 32'd1);
      rst_n = 1'b0;
      #2;
      check_eq("rst_async_outputs", 32'(obs), 32'(E_IDLE));
      check_eq("rst_async_cnt", 32'(cmd_cnt), 32'd0);
      step();
      rst_n = 1'b1;
      step();
      check_eq("rst_release_idle", 32'(obs), 32'(E_IDLE));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ddr_controller_engine.md
# ddr_controller_engine

Controller-side HDR-DDR sequencing engine. It is the initiator counterpart of the target engine. It takes a host request to enter HDR-DDR and drives the ENTHDR CCC. It then dispatches each queued command to the normal-transaction (NT) or CCC sub-engine, separates back-to-back commands with HDR Restart patterns, and closes the session with an HDR Exit pattern. It owns the SDA/SCL driver select mux and a per-command watchdog.

## Interface
- `TIMEOUT`, default 1024: cycles allowed in DDR_NT/CCC_HANDLER before abort; must be ≥ 2.
- `CNT_W`, default 8: width of the completed-command counter.

- `i_sys_clk`  in  1  system clock
- `i_sys_rst`  in  1  asynchronous, active-low reset
- `i_hdr_req`  in  1  host requests an HDR-DDR session (level)
- `i_cmd_type`  in  2  head-of-queue command: 01 = regular DDR, 10 = CCC, 00/11 = invalid
- `i_more_cmds`  in  1  command queue non-empty after current command
- `i_ENTHDR_done`  in  1  pulse: ENTHDR CCC fully sent
- `i_NT_done`  in  1  pulse: NT sub-engine finished
- `i_CCC_done`  in  1  pulse: CCC sub-engine finished
- `i_sub_error`  in  1  pulse: NACK/parity/CRC error from active sub-engine
- `i_pattern_done`  in  1  pulse: restart/exit pattern generator finished
- `o_muxes`  out  2  driver select: 00 engine, 01 ddr_nt, 10 ccc, 11 pattern
- `o_ENTHDR_en`  out  1  enable ENTHDR sender
- `o_NT_en`  out  1  enable NT sub-engine
- `o_CCC_en`  out  1  enable CCC sub-engine
- `o_pattern_en`  out  1  enable pattern generator
- `o_pattern_sel`  out  1  0 = HDR Restart, 1 = HDR Exit
- `o_abort`  out  1  one-cycle pulse on watchdog expiry or error
- `o_busy`  out  1  high in every state except IDLE_SDR
- `o_cmd_cnt`  out  CNT_W  commands completed in the current session

## Operation
- States: IDLE_SDR, ENTHDR, DISPATCH, DDR_NT, CCC_HANDLER, RESTART, EXIT.
- IDLE_SDR: goes to ENTHDR on `i_hdr_req`=1. Clears `o_cmd_cnt` on that transition.
- ENTHDR: goes to DISPATCH on `i_ENTHDR_done`.
- DISPATCH (exactly 1 cycle), based on `i_cmd_type`:
  - 01 → DDR_NT
  - 10 → CCC_HANDLER
  - 00/11 → EXIT, with an `o_abort` pulse
- DDR_NT / CCC_HANDLER, evaluated in this order:
  - `i_sub_error` → EXIT + `o_abort`
  - otherwise the matching done → increment `o_cmd_cnt`, then go to RESTART if `i_more_cmds`, else EXIT
  - otherwise the watchdog reaching TIMEOUT → EXIT + `o_abort`
- RESTART: `o_pattern_sel`=0. Goes to DISPATCH on `i_pattern_done`.
- EXIT: `o_pattern_sel`=1. Goes to IDLE_SDR on `i_pattern_done`.
- Done/error pulses arriving in a non-matching state are ignored. Example: `i_CCC_done` while in DDR_NT.
- Outputs per state (all other enables 0):
  - IDLE_SDR, DISPATCH: `o_muxes`=00
  - ENTHDR: `o_muxes`=00, `o_ENTHDR_en`=1
  - DDR_NT: `o_muxes`=01, `o_NT_en`=1
  - CCC_HANDLER: `o_muxes`=10, `o_CCC_en`=1
  - RESTART/EXIT: `o_muxes`=11, `o_pattern_en`=1
- Watchdog: `$clog2(TIMEOUT+1)`-bit counter. Cleared on entry to DDR_NT/CCC_HANDLER, increments every cycle while in either state, saturates.
- `o_cmd_cnt` wraps modulo 2^CNT_W. It holds its value after EXIT until the next session starts.

## Timing
- Reset: state IDLE_SDR; all enables 0, `o_muxes`=00, `o_pattern_sel`=0, `o_abort`=0, `o_busy`=0, `o_cmd_cnt`=0, watchdog=0.
- Outputs are registered and decoded from next-state. They are valid in the first cycle the state is occupied, i.e. one clock after the triggering input is sampled.
- `o_abort` is high for exactly the one cycle in which EXIT is first occupied.
- Watchdog expiry: with no done and no error, the state leaves DDR_NT/CCC_HANDLER after exactly TIMEOUT cycles of occupancy.
- Done and error in the same cycle: error wins, and `o_cmd_cnt` does not increment.
- Done and watchdog expiry in the same cycle: done wins, no abort.
- `i_hdr_req` is ignored outside IDLE_SDR. If it is held high through EXIT, a new session starts one cycle after IDLE_SDR is re-entered.
- Reset asserted mid-session: immediate return to reset values. No exit pattern is generated.

## Structure
- Shared package `ddr_ctrl_pkg` holds:
  - state enum
  - `o_muxes` encodings (ENGINE, DDR_NT, CCC, PATTERN)
  - `i_cmd_type` encodings (CMD_REG, CMD_CCC)
  - pattern select constants (PAT_RESTART, PAT_EXIT)
- One sub-module, `ddr_watchdog`: clear, enable, expired outputs, parameterized by TIMEOUT. All other logic is flat in the engine.

## Test plan
- Reset release → all outputs at reset values. `i_hdr_req`=1 → next cycle `o_ENTHDR_en`=1, `o_busy`=1, `o_muxes`=00.
- `i_ENTHDR_done`, `i_cmd_type`=01, `i_more_cmds`=0, then `i_NT_done` → `o_muxes`=01 then 11, `o_pattern_sel`=1, `o_cmd_cnt`=1. `i_pattern_done` → IDLE_SDR, `o_busy`=0.
- Three commands (01, 10, 01) with `i_more_cmds`=1,1,0 → sequence NT, RESTART, CCC, RESTART, NT, EXIT; `o_muxes` 01,11,10,11,01,11; final `o_cmd_cnt`=3.
- TIMEOUT=16, DDR_NT with no done → exit after exactly 16 cycles, one-cycle `o_abort`, `o_cmd_cnt` unchanged. Second run: done on cycle 16 → no abort, count +1.
- `i_sub_error` and `i_CCC_done` in the same cycle → EXIT, `o_abort`=1, no increment. `i_cmd_type`=11 in DISPATCH → EXIT + abort.
- `i_sys_rst`=0 asserted in CCC_HANDLER → all outputs return to reset values asynchronously, before the next clock edge.
